// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
//            Converts one BIN_W-bit unsigned value per accepted start, one bit
//            per clock, and publishes five BCD digits atomically together
//            with a one-cycle done pulse. Digits hold between conversions.
// Macro    : BIN_TO_BCD_BLANK_EN - when defined, leading-zero digits (digit5
//            down to digit2) are published as blank code 4'hF.
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous active-low reset
//            start   - conversion request, honoured only in IDLE
//            bin     - binary value, captured on the accepted start edge
//            busy    - high from accepted start through the DONE cycle
//            done    - one-cycle pulse, coincident with the digit update
//            digit1..digit5 - ones .. ten-thousands digits
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4,
  output logic [3:0]       digit5
);

  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [19:0]        scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        digits_q, digits_d;
  logic               done_q, done_d;

  logic [19:0]        adj;      // scratch after the parallel +3 correction
  logic [19:0]        shifted;  // scratch after this cycle's shift
  logic [19:0]        fmt;      // value to publish on the final shift edge

  // Add-3 correction on every nibble in parallel, before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[18:0], shreg_q[BIN_W-1]};
  end

`ifdef BIN_TO_BCD_BLANK_EN
  // Blank leading zeros from digit5 downward; digit1 always shows a value.
  logic lead;
  always_comb begin
    fmt  = shifted;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (shifted[4*i +: 4] == 4'd0)) begin
        fmt[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    fmt = shifted;
  end
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = 20'd0;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = shifted;
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          // The final shift edge is also the publish edge, so the digits
          // and done are loaded from the freshly shifted value here.
          state_d  = S_DONE;
          digits_d = fmt;
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= 20'd0;
      cnt_q     <= '0;
      digits_q  <= 20'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign digit1 = digits_q[3:0];
  assign digit2 = digits_q[7:4];
  assign digit3 = digits_q[11:8];
  assign digit4 = digits_q[15:12];
  assign digit5 = digits_q[19:16];

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Directed self-checking bench for bin_to_bcd_seq (BIN_W = 16).
//            Expected digits are hand-computed raw BCD; with
//            BIN_TO_BCD_BLANK_EN defined they are passed through the
//            leading-zero blanking rule before comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  digit1, digit2, digit3, digit4, digit5;
  logic [19:0] digs;

  int n_vec = 0;
  int n_err = 0;

  bin_to_bcd_seq #(.BIN_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4),
    .digit5 (digit5)
  );

  assign digs = {digit5, digit4, digit3, digit2, digit1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] shown(input logic [19:0] raw);
    logic [19:0] r;
    r = raw;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else break;
    end
`endif
    return r;
  endfunction

  // Step edges until done is seen (bounded); flags any digit change before it.
  task automatic wait_done(output int cyc, output bit stable);
    logic [19:0] prev;
    prev   = digs;
    cyc    = 0;
    stable = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1 && digs !== prev) stable = 1'b0;
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] v, input logic [19:0] raw);
    int  cyc;
    bit  stable;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = ~v;
    check({tag, "_busy"}, busy, 1);
    wait_done(cyc, stable);
    check({tag, "_lat"}, cyc, 16);
    check({tag, "_hold"}, stable, 1);
    check({tag, "_digits"}, digs, shown(raw));
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int cyc, pulses;
    bit stable;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_digits", digs, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("zero", 16'd0, 20'h00000);
    run("max", 16'd65535, 20'h65535);

    // Back-to-back with start held high.
    start = 1'b1;
    bin   = 16'd1234;
    @(posedge clk); #1;
    bin = 16'd9;
    wait_done(cyc, stable);
    check("b2b1_lat", cyc, 16);
    check("b2b1_digits", digs, shown(20'h01234));
    @(posedge clk); #1;
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);
    wait_done(cyc, stable);
    check("b2b2_period", cyc + 1, 18);
    check("b2b2_hold", stable, 1);
    check("b2b2_digits", digs, shown(20'h00009));
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b2_done_low", done, 0);
    check("b2b2_busy_low", busy, 0);

    // Start pulsed while busy is ignored.
    start = 1'b1;
    bin   = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, stable);
    check("ign_lat", cyc + 5, 16);
    check("ign_digits", digs, shown(20'h00500));
    count_done(20, pulses);
    check("ign_single_done", pulses, 0);
    check("ign_busy_low", busy, 0);

    // Reset mid-conversion.
    start = 1'b1;
    bin   = 16'd4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_digits", digs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_done(20, pulses);
    check("mid_rst_no_done", pulses, 0);
    run("after_rst", 16'd4321, 20'h04321);

    run("seven", 16'd7, 20'h00007);
    run("interior0", 16'd10005, 20'h10005);
    run("zero_again", 16'd0, 20'h00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
